// File: rtl/byte_mem_responder.sv
// Serves 8/16-bit CPU data-bus requests from a byte-wide asynchronous-read memory.
// A word is split into two byte accesses: low byte at addr, high byte at addr+1.
module byte_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic              word,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_en,
    output logic              mem_we
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_next_cnt;
    logic              r_we;
    logic              r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata_hi;
    logic [7:0]        r_asm_lo;
    logic [15:0]       r_rdata;
    logic              r_ack;
    logic              r_busy;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic              w_last;
    logic              w_accept;
    logic              w_we_src;
    logic              w_next_mem_en;
    logic              w_next_mem_we;
    logic [ADDR_W-1:0] w_next_mem_addr;
    logic [7:0]        w_next_mem_wdata;
    logic              w_cap_lo;
    logic              w_cap_hi;
    logic [15:0]       w_next_rdata;

    // Next state plus the values every registered output takes in that state.
    always_comb begin
        w_last           = (r_wait_cnt == WS_L);
        w_accept         = (r_state == S_IDLE) && req;
        w_next_state     = r_state;
        w_next_cnt       = 4'd0;
        w_we_src         = r_we;
        w_next_mem_addr  = r_mem_addr;
        w_next_mem_wdata = r_mem_wdata;
        w_cap_lo         = 1'b0;
        w_cap_hi         = 1'b0;
        w_next_rdata     = r_rdata;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next_state = S_LO;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LO: begin
                if (w_last) begin
                    if (r_word) begin
                        w_next_state = S_HI;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end else begin
                    w_next_state = S_LO;
                end
            end
            S_HI: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_HI;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase

        if (((r_state == S_LO) || (r_state == S_HI)) && !w_last) begin
            w_next_cnt = r_wait_cnt + 4'd1;
        end else begin
            w_next_cnt = 4'd0;
        end

        // On acceptance the latched copies are not yet loaded, so use the bus fields.
        if (w_accept) begin
            w_we_src         = we;
            w_next_mem_addr  = addr;
            w_next_mem_wdata = wdata[7:0];
        end else if ((r_state == S_LO) && w_last && r_word) begin
            w_we_src         = r_we;
            w_next_mem_addr  = r_addr + ADDR_W'(1);
            w_next_mem_wdata = r_wdata_hi;
        end else begin
            w_we_src         = r_we;
            w_next_mem_addr  = r_mem_addr;
            w_next_mem_wdata = r_mem_wdata;
        end

        w_next_mem_en = (w_next_state == S_LO) || (w_next_state == S_HI);
        w_next_mem_we = w_next_mem_en && w_we_src && (w_next_cnt == WS_L);

        w_cap_lo = (r_state == S_LO) && w_last && !r_we;
        w_cap_hi = (r_state == S_HI) && w_last && !r_we;
        if (w_cap_lo && !r_word) begin
            w_next_rdata = {8'h00, mem_rdata};
        end else if (w_cap_hi) begin
            w_next_rdata = {mem_rdata, r_asm_lo};
        end else begin
            w_next_rdata = r_rdata;
        end
    end

    // State register and per-byte wait counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
        end
    end

    // Request fields latched at acceptance and the low-byte assembly register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_we       <= 1'b0;
            r_word     <= 1'b0;
            r_addr     <= '0;
            r_wdata_hi <= 8'h00;
            r_asm_lo   <= 8'h00;
        end else begin
            if (w_accept) begin
                r_we       <= we;
                r_word     <= word;
                r_addr     <= addr;
                r_wdata_hi <= wdata[15:8];
            end
            if (w_cap_lo) begin
                r_asm_lo <= mem_rdata;
            end
        end
    end

    // Registered bus and memory-port outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata     <= 16'h0000;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
        end else begin
            r_rdata     <= w_next_rdata;
            r_ack       <= (w_next_state == S_DONE);
            r_busy      <= (w_next_state != S_IDLE);
            r_mem_en    <= w_next_mem_en;
            r_mem_we    <= w_next_mem_we;
            r_mem_addr  <= w_next_mem_addr;
            r_mem_wdata <= w_next_mem_wdata;
        end
    end

    assign rdata     = r_rdata;
    assign ack       = r_ack;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_byte_mem_responder.sv
// Bench for byte_mem_responder: three instances (WAIT_STATES 0,1,2), a transaction-level
// timing model checked every cycle, plus directed transfers with literal expectations.
module tb_byte_mem_responder;

    localparam int NI = 3;

    logic        clk;
    logic        rst_n   [NI];
    logic        req     [NI];
    logic        we      [NI];
    logic        word    [NI];
    logic [15:0] addr    [NI];
    logic [15:0] wdata   [NI];
    logic [15:0] rdata   [NI];
    logic        ack     [NI];
    logic        busy    [NI];
    logic [15:0] maddr   [NI];
    logic [7:0]  mwdata  [NI];
    logic [7:0]  mrdata  [NI];
    logic        men     [NI];
    logic        mwe     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        byte_mem_responder #(.ADDR_W(16), .WAIT_STATES(g)) u_dut (
            .clk       (clk),
            .reset_n   (rst_n[g]),
            .req       (req[g]),
            .we        (we[g]),
            .word      (word[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .rdata     (rdata[g]),
            .ack       (ack[g]),
            .busy      (busy[g]),
            .mem_addr  (maddr[g]),
            .mem_wdata (mwdata[g]),
            .mem_rdata (mrdata[g]),
            .mem_en    (men[g]),
            .mem_we    (mwe[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: a fixed pattern, overridden by bytes actually written.
    logic [7:0] memw [int];
    logic [7:0] refm [int];

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a)
            16'h0011: return 8'hA5;
            16'hFFFF: return 8'h34;
            16'h0000: return 8'h12;
            default:  return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    function automatic int mkey(input int i, input logic [15:0] a);
        return i * 65536 + int'(a);
    endfunction

    function automatic logic [7:0] mem_rd(input int i, input logic [15:0] a);
        if (memw.exists(mkey(i, a))) return memw[mkey(i, a)];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input int i, input logic [15:0] a);
        if (refm.exists(mkey(i, a))) return refm[mkey(i, a)];
        return init_byte(a);
    endfunction

    // Bench memories: write on the clock edge, asynchronous read shortly after.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                if (men[i] === 1'b1 && mwe[i] === 1'b1) memw[mkey(i, maddr[i])] = mwdata[i];
            end
            #2;
            for (int i = 0; i < NI; i++) begin
                if ((^maddr[i]) === 1'bx) mrdata[i] = 8'h00;
                else mrdata[i] = mem_rd(i, maddr[i]);
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction model: k counts cycles since the accepting edge.
    logic        m_act  [NI];
    int          m_k    [NI];
    logic        m_we   [NI];
    logic        m_word [NI];
    logic [15:0] m_addr [NI];
    logic [15:0] m_wdata[NI];
    logic [15:0] e_rdata[NI];
    logic [15:0] e_maddr[NI];
    logic [7:0]  e_mwd  [NI];
    logic        e_ack  [NI];
    logic        e_busy [NI];
    logic        e_men  [NI];
    logic        e_mwe  [NI];

    task automatic check(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, i, got, exp);
        end
    endtask

    task automatic model_step(input int i);
        int n, t, span, off;
        logic hi;
        n = i + 1;
        if (!rst_n[i]) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_we[i] = 1'b0; m_word[i] = 1'b0;
            m_addr[i] = 16'h0; m_wdata[i] = 16'h0;
            e_rdata[i] = 16'h0; e_maddr[i] = 16'h0; e_mwd[i] = 8'h00;
        end else if (m_act[i]) begin
            m_k[i]++;
            t = m_word[i] ? 2 * n + 1 : n + 1;
            if (m_k[i] > t) m_act[i] = 1'b0;
        end else if (req[i]) begin
            m_act[i] = 1'b1; m_k[i] = 1;
            m_we[i] = we[i]; m_word[i] = word[i]; m_addr[i] = addr[i]; m_wdata[i] = wdata[i];
        end
        t    = m_word[i] ? 2 * n + 1 : n + 1;
        span = m_word[i] ? 2 * n : n;
        e_busy[i] = m_act[i];
        e_ack[i]  = m_act[i] && (m_k[i] == t);
        e_men[i]  = m_act[i] && (m_k[i] <= span);
        e_mwe[i]  = 1'b0;
        if (e_men[i]) begin
            hi  = (m_k[i] > n);
            off = hi ? m_k[i] - n : m_k[i];
            e_maddr[i] = hi ? m_addr[i] + 16'd1 : m_addr[i];
            e_mwd[i]   = hi ? m_wdata[i][15:8] : m_wdata[i][7:0];
            if (m_we[i] && off == n) begin
                e_mwe[i] = 1'b1;
                refm[mkey(i, e_maddr[i])] = e_mwd[i];
            end
        end
        if (e_ack[i] && !m_we[i]) begin
            e_rdata[i] = {m_word[i] ? ref_rd(i, m_addr[i] + 16'd1) : 8'h00, ref_rd(i, m_addr[i])};
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            model_step(i);
            check("ack",       i, 16'(ack[i]),  16'(e_ack[i]));
            check("busy",      i, 16'(busy[i]), 16'(e_busy[i]));
            check("mem_en",    i, 16'(men[i]),  16'(e_men[i]));
            check("mem_we",    i, 16'(mwe[i]),  16'(e_mwe[i]));
            check("mem_addr",  i, maddr[i],     e_maddr[i]);
            check("mem_wdata", i, 16'(mwdata[i]), 16'(e_mwd[i]));
            check("rdata",     i, rdata[i],     e_rdata[i]);
        end
    endtask

    task automatic run_txn(input int i, input logic w, input logic wd, input logic [15:0] a,
                           input logic [15:0] d, output int lat, output int en_cnt, output int we_cnt);
        we[i] = w; word[i] = wd; addr[i] = a; wdata[i] = d; req[i] = 1'b1;
        cycle();
        req[i] = 1'b0; we[i] = ~w; word[i] = ~wd; addr[i] = ~a; wdata[i] = ~d;
        lat = 1;
        en_cnt = (men[i] === 1'b1) ? 1 : 0;
        we_cnt = (mwe[i] === 1'b1) ? 1 : 0;
        while (ack[i] !== 1'b1 && lat < 60) begin
            cycle();
            lat++;
            if (men[i] === 1'b1) en_cnt++;
            if (mwe[i] === 1'b1) we_cnt++;
        end
        if (lat >= 60) begin
            n_checks++; n_fail++;
            $display("FAIL ack_timeout dut%0d: got no ack within 60 cycles", i);
        end
        cycle();
    endtask

    initial begin
        int lat, enc, wec, acks, ack1_cyc, en2_cyc;
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; word[i] = 1'b0;
            addr[i] = 16'h0; wdata[i] = 16'h0;
        end
        repeat (3) cycle();
        check("rst_rdata", 0, rdata[0], 16'h0000);
        check("rst_busy",  0, 16'(busy[0]), 16'h0000);
        check("rst_maddr", 2, maddr[2], 16'h0000);
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        cycle();

        // Byte read, no wait states.
        run_txn(0, 1'b0, 1'b0, 16'h0011, 16'h0000, lat, enc, wec);
        check("t1_lat", 0, 16'(lat), 16'd2);
        check("t1_en",  0, 16'(enc), 16'd1);
        check("t1_we",  0, 16'(wec), 16'd0);
        check("t1_rdata", 0, rdata[0], 16'h00A5);
        check("t1_model", 0, e_rdata[0], 16'h00A5);

        // Word write at an odd address; rdata must keep the previous read.
        run_txn(0, 1'b1, 1'b1, 16'h0021, 16'hBEEF, lat, enc, wec);
        check("t2_lat", 0, 16'(lat), 16'd3);
        check("t2_en",  0, 16'(enc), 16'd2);
        check("t2_we",  0, 16'(wec), 16'd2);
        check("t2_rdata", 0, rdata[0], 16'h00A5);
        check("t2_mem21", 0, 16'(mem_rd(0, 16'h0021)), 16'h00EF);
        check("t2_mem22", 0, 16'(mem_rd(0, 16'h0022)), 16'h00BE);
        check("t2_model", 0, 16'(ref_rd(0, 16'h0022)), 16'h00BE);

        // Word read wrapping from 0xFFFF to 0x0000, two wait states.
        run_txn(2, 1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, enc, wec);
        check("t3_lat", 2, 16'(lat), 16'd7);
        check("t3_en",  2, 16'(enc), 16'd6);
        check("t3_we",  2, 16'(wec), 16'd0);
        check("t3_rdata", 2, rdata[2], 16'h1234);
        check("t3_model", 2, e_rdata[2], 16'h1234);

        // Byte write, one wait state: high byte of wdata and addr+1 untouched.
        run_txn(1, 1'b1, 1'b0, 16'h0100, 16'h77CC, lat, enc, wec);
        check("t4_lat", 1, 16'(lat), 16'd3);
        check("t4_en",  1, 16'(enc), 16'd2);
        check("t4_we",  1, 16'(wec), 16'd1);
        check("t4_mem100", 1, 16'(mem_rd(1, 16'h0100)), 16'h00CC);
        check("t4_mem101_untouched", 1, 16'(memw.exists(mkey(1, 16'h0101))), 16'd0);
        check("t4_rdata", 1, rdata[1], 16'h0000);

        // req held high across two word reads; inputs toggled during the second.
        we[0] = 1'b0; word[0] = 1'b1; addr[0] = 16'h0030; wdata[0] = 16'h0000; req[0] = 1'b1;
        acks = 0; ack1_cyc = -1; en2_cyc = -1;
        for (int n = 0; n < 60 && acks < 2; n++) begin
            cycle();
            if (ack[0] === 1'b1) begin
                acks++;
                if (acks == 1) ack1_cyc = cyc;
            end else if (acks == 1 && men[0] === 1'b1 && en2_cyc < 0) begin
                en2_cyc = cyc;
            end
            if (acks == 1 && en2_cyc >= 0) begin
                req[0] = ~req[0];
                addr[0] = addr[0] ^ 16'h0F0F;
            end
        end
        req[0] = 1'b0;
        cycle();
        cycle();
        check("t5_acks", 0, 16'(acks), 16'd2);
        check("t5_gap",  0, 16'(en2_cyc - ack1_cyc), 16'd2);
        check("t5_rdata", 0, rdata[0], 16'h0D0C);

        // Reset during the high-byte phase of a word write.
        we[1] = 1'b1; word[1] = 1'b1; addr[1] = 16'h0040; wdata[1] = 16'h5A6B; req[1] = 1'b1;
        cycle();
        req[1] = 1'b0;
        cycle();
        cycle();
        check("t6_in_hi", 1, maddr[1], 16'h0041);
        rst_n[1] = 1'b0;
        cycle();
        check("t6_ack",   1, 16'(ack[1]),  16'd0);
        check("t6_busy",  1, 16'(busy[1]), 16'd0);
        check("t6_men",   1, 16'(men[1]),  16'd0);
        check("t6_maddr", 1, maddr[1], 16'h0000);
        rst_n[1] = 1'b1;
        repeat (4) cycle();
        check("t6_mem40", 1, 16'(mem_rd(1, 16'h0040)), 16'h006B);
        check("t6_mem41_untouched", 1, 16'(memw.exists(mkey(1, 16'h0041))), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
